// File: rtl/ex_mem_buffer.sv
// EX/MEM elastic stage: two-entry skid buffer carrying ALU result and MEM/WB control.
// Optional EXMEM_STALL_CNT_EN adds a saturating count of cycles where MEM back-pressures.
module ex_mem_buffer #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_zero,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [REG_W-1:0]  in_dest,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              in_mem_to_reg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic [DATA_W-1:0] out_store_data,
  output logic [REG_W-1:0]  out_dest,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_mem_to_reg
`ifdef EXMEM_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  dest;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
  } ent_t;

  ent_t main_q, skid_q, cap;
  logic main_vld, skid_vld, rdy_q;
  logic in_xfer, out_xfer;

  assign in_xfer  = in_valid & rdy_q;
  assign out_xfer = main_vld & out_ready;

  // Writes to r0 are architecturally discarded; kill them at capture.
  always_comb begin
    cap.result     = in_result;
    cap.zero       = in_zero;
    cap.store_data = in_store_data;
    cap.dest       = in_dest;
    cap.reg_write  = in_reg_write & (in_dest != '0);
    cap.mem_read   = in_mem_read;
    cap.mem_write  = in_mem_write;
    cap.mem_to_reg = in_mem_to_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      rdy_q    <= 1'b1;
    end else if (flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      rdy_q    <= 1'b1;
    end else if (!main_vld) begin
      if (in_xfer) begin
        main_q   <= cap;
        main_vld <= 1'b1;
      end
    end else if (!skid_vld) begin
      if (out_xfer && in_xfer) begin
        main_q <= cap;
      end else if (out_xfer) begin
        main_vld <= 1'b0;
      end else if (in_xfer) begin
        skid_q   <= cap;
        skid_vld <= 1'b1;
        rdy_q    <= 1'b0;
      end
    end else if (out_xfer) begin
      // Full: older entry already left, skid takes its place.
      main_q   <= skid_q;
      skid_vld <= 1'b0;
      rdy_q    <= 1'b1;
    end
  end

  assign in_ready       = rdy_q;
  assign out_valid      = main_vld;
  assign out_result     = main_q.result;
  assign out_zero       = main_q.zero;
  assign out_store_data = main_q.store_data;
  assign out_dest       = main_q.dest;
  assign out_reg_write  = main_q.reg_write;
  assign out_mem_read   = main_q.mem_read;
  assign out_mem_write  = main_q.mem_write;
  assign out_mem_to_reg = main_q.mem_to_reg;

`ifdef EXMEM_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (main_vld && !out_ready && stall_cnt != 32'hFFFF_FFFF)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ex_mem_buffer.sv
// Directed bench for ex_mem_buffer: reset, streaming, backpressure, flush, r0 rule, stall count.
module tb_ex_mem_buffer;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DATA_W-1:0] in_result, in_store_data, out_result, out_store_data;
  logic [REG_W-1:0]  in_dest, out_dest;
  logic              in_zero, in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg;
  logic              out_zero, out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg;
`ifdef EXMEM_STALL_CNT_EN
  logic [31:0]       stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_mem_buffer #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_zero(in_zero), .in_store_data(in_store_data),
    .in_dest(in_dest), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_mem_to_reg(in_mem_to_reg),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_store_data(out_store_data),
    .out_dest(out_dest), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg)
`ifdef EXMEM_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] dst, input logic rw);
    in_valid      = v;
    in_result     = res;
    in_dest       = dst;
    in_reg_write  = rw;
    in_store_data = ~res;
    in_zero       = (res == 0);
    in_mem_read   = 1'b0;
    in_mem_write  = 1'b0;
    in_mem_to_reg = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    step(); step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_dest", {27'd0, out_dest}, 32'd0);
    rst_n = 1'b1;

    // single entry
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_0005, 5'd8, 1'b1);
    step();
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_result", out_result, 32'd5);
    chk("single_dest", {27'd0, out_dest}, 32'd8);
    chk("single_rw", {31'd0, out_reg_write}, 32'd1);
    chk("single_store", out_store_data, 32'hFFFF_FFFA);
    chk("single_in_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    step();
    chk("single_drain", {31'd0, out_valid}, 32'd0);

    // streaming
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, i, 5'd3, 1'b1);
      step();
      chk("stream_result", out_result, i);
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
    end
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    step();
    chk("stream_drain", {31'd0, out_valid}, 32'd0);

    // backpressure fill, then ordered drain
    out_ready = 1'b0;
    drive(1'b1, 32'hAAAA_0000, 5'd1, 1'b1);
    step();
    chk("bp_a_result", out_result, 32'hAAAA_0000);
    chk("bp_a_in_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 32'hBBBB_0000, 5'd2, 1'b1);
    step();
    chk("bp_b_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_b_head", out_result, 32'hAAAA_0000);
    drive(1'b1, 32'hCCCC_0000, 5'd3, 1'b1);
    step();
    chk("bp_c_held_rdy", {31'd0, in_ready}, 32'd0);
    chk("bp_c_held_head", out_result, 32'hAAAA_0000);
    chk("bp_c_held_dest", {27'd0, out_dest}, 32'd1);
    out_ready = 1'b1;
    step();
    chk("bp_drain_b", out_result, 32'hBBBB_0000);
    chk("bp_drain_b_dest", {27'd0, out_dest}, 32'd2);
    chk("bp_drain_rdy", {31'd0, in_ready}, 32'd1);
    step();
    chk("bp_drain_c", out_result, 32'hCCCC_0000);
    chk("bp_drain_c_v", {31'd0, out_valid}, 32'd1);
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    step();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // flush while full drops held entries and the concurrent input
    out_ready = 1'b0;
    drive(1'b1, 32'hAAAA_0000, 5'd1, 1'b1);
    step();
    drive(1'b1, 32'hBBBB_0000, 5'd2, 1'b1);
    step();
    chk("fl_full", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 32'hCCCC_0000, 5'd3, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    out_ready = 1'b1;
    step();
    chk("fl_no_c", {31'd0, out_valid}, 32'd0);

    // register-zero rule plus payload hold under stall
    out_ready = 1'b0;
    drive(1'b1, 32'h1234_5678, 5'd0, 1'b1);
    in_mem_write = 1'b1;
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    chk("r0_rw", {31'd0, out_reg_write}, 32'd0);
    chk("r0_mw", {31'd0, out_mem_write}, 32'd1);
    chk("r0_result", out_result, 32'h1234_5678);
    step();
    chk("hold_result", out_result, 32'h1234_5678);
    chk("hold_mw", {31'd0, out_mem_write}, 32'd1);
    chk("hold_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    step();
    chk("r0_drain", {31'd0, out_valid}, 32'd0);

`ifdef EXMEM_STALL_CNT_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("sc_rst", stall_cnt, 32'd0);
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0077, 5'd4, 1'b1);
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    for (int i = 0; i < 5; i++) step();
    chk("sc_five", stall_cnt, 32'd5);
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("sc_flush_keep", stall_cnt, 32'd5);
    chk("sc_flush_v", {31'd0, out_valid}, 32'd0);
    step();
    chk("sc_idle_keep", stall_cnt, 32'd5);
`endif

    // asynchronous reset mid-cycle with a full buffer
    out_ready = 1'b0;
    drive(1'b1, 32'hDEAD_0001, 5'd6, 1'b1);
    step();
    drive(1'b1, 32'hDEAD_0002, 5'd7, 1'b1);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_result", out_result, 32'd0);
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("arst_no_survivor", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/ex_mem_buffer.md
Name: ex_mem_buffer

Overview:
- Elastic EX/MEM pipeline stage directly downstream of the ALU.
- Captures the ALU result and zero flag, together with store data, destination register and memory/writeback control bits, for the MEM stage.
- Two-entry skid buffer with valid/ready handshakes on both sides, so MEM-stage stalls never create a combinational ready path back into EX.
- Synchronous flush for branch and exception squash.

Parameters:
DATA_W, 32, width of ALU result and store data
REG_W, 5, width of destination register index

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous squash of all buffered entries
in_valid  input  1  EX presents a valid entry
in_ready  output  1  buffer can accept an entry (registered)
in_result  input  DATA_W  ALU result
in_zero  input  1  ALU zero flag
in_store_data  input  DATA_W  busB value for stores
in_dest  input  REG_W  destination register index
in_reg_write  input  1  writeback enable
in_mem_read  input  1  load
in_mem_write  input  1  store
in_mem_to_reg  input  1  writeback selects memory data
out_valid  output  1  MEM-side entry valid
out_ready  input  1  MEM stage accepts entry
out_result, out_zero, out_store_data, out_dest, out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg  output  (matching widths)  head entry payload

Behaviour:
- Clock and reset: one clock domain; rst_n is asynchronous, active-low.
- Storage: main register (drives outputs) plus skid register, each with a valid bit.
- Handshake: input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
- Reset values: all valid bits 0; out_valid=0; in_ready=1; every payload output 0. Deasserting rst_n mid-transfer discards everything; no partial entry survives.
- in_ready = !skid_valid, driven directly from a flop. It never depends combinationally on out_ready.
- Latency: an entry accepted at edge N appears on the outputs after edge N (1 cycle) when the main register is empty or drains at that same edge.
- State transitions per rising edge (flush=0):
  - EMPTY (main 0, skid 0): input transfer -> main loaded -> ONE.
  - ONE (main 1, skid 0):
    - output transfer and input transfer -> main reloaded, stays ONE;
    - output transfer only -> EMPTY;
    - input transfer only -> skid loaded -> FULL.
  - FULL (main 1, skid 1): in_ready=0. Output transfer -> skid moves to main, skid cleared -> ONE.
- Ordering: strict FIFO; the skid entry never overtakes the main entry.
- Flush: both valid bits cleared at the next edge, regardless of the handshake.
  - An in_valid presented in the same cycle as flush is dropped.
  - out_valid=0 and in_ready=1 in the cycle after flush.
  - Payload registers need not clear on flush.
- Register-zero rule: on capture, reg_write is forced to 0 when in_dest==0. All other fields are stored unchanged.
- Payload stability: while out_valid=1 and out_ready=0, all out_* fields hold stable.
- Width: payload is stored verbatim; there is no arithmetic on the data path.

Optional Feature:
- Macro: EXMEM_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt, 32 bits.
  - Counts cycles where out_valid=1 and out_ready=0.
  - Saturates at 32'hFFFF_FFFF.
  - Reset to 0 by rst_n only; not cleared by flush.
- When undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset then single entry: release rst_n, in_valid=1 with result=32'h0000_0005, dest=5'd8, reg_write=1, out_ready=1 -> next cycle out_valid=1, out_result=5, out_dest=8, out_reg_write=1; in_ready stays 1.
- Back-to-back streaming: 8 consecutive entries with result=1..8 and out_ready held 1 -> outputs 1..8 on consecutive cycles, in_ready never drops.
- Backpressure fill: out_ready=0 while entries A=32'hAAAA_0000 and B=32'hBBBB_0000 are sent -> in_ready=0 after B; C is held off. Raise out_ready -> A, then B, then C emerge in order with no loss or duplication.
- Flush while FULL: buffer holds A and B, assert flush with in_valid=1 and payload C -> next cycle out_valid=0, in_ready=1; C never appears on the outputs.
- Register-zero rule: in_dest=0, in_reg_write=1, mem_write=1 -> out_reg_write=0, out_mem_write=1.
- Stall counter (EXMEM_STALL_CNT_EN defined): hold out_valid=1 with out_ready=0 for 5 cycles -> stall_cnt=5; assert flush -> stall_cnt remains 5.
